// File: rtl/instr_fetch_if.sv
// Fetch-stage bus between the instr_fetch unit and its surroundings (instruction
// memory, decode/sign-extension, ALU flags, debug controls).
//   slave  : seen by instr_fetch (consumes memory data/control, drives PC/fetch outputs)
//   master : seen by the environment driving instr_fetch
// Signals: IMEM_RDATA, IMM_EXT, BRANCH, ZERO, JUMP, STEP_MODE, STEP (into fetch);
//          IMEM_ADDR, PC, PC_PLUS4, INSTR, IMM, EXEC_EN, HALTED, INSTR_COUNT (out of fetch).
interface instr_fetch_if;
  logic [31:0] IMEM_RDATA;
  logic [31:0] IMM_EXT;
  logic        BRANCH;
  logic        ZERO;
  logic        JUMP;
  logic        STEP_MODE;
  logic        STEP;
  logic [31:0] IMEM_ADDR;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic [31:0] INSTR;
  logic [15:0] IMM;
  logic        EXEC_EN;
  logic        HALTED;
  logic [31:0] INSTR_COUNT;

  modport slave (
    input  IMEM_RDATA, IMM_EXT, BRANCH, ZERO, JUMP, STEP_MODE, STEP,
    output IMEM_ADDR, PC, PC_PLUS4, INSTR, IMM, EXEC_EN, HALTED, INSTR_COUNT
  );

  modport master (
    output IMEM_RDATA, IMM_EXT, BRANCH, ZERO, JUMP, STEP_MODE, STEP,
    input  IMEM_ADDR, PC, PC_PLUS4, INSTR, IMM, EXEC_EN, HALTED, INSTR_COUNT
  );
endinterface

// File: rtl/instr_fetch.sv
// Program counter and instruction fetch for the single-cycle MIPS core, with
// run / single-step / halt-on-BREAK debug control.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset (highest priority, also exits HALT)
//   bus  : instr_fetch_if.slave -- memory read data, immediate feedback, branch/jump
//          controls and step controls in; PC, fetch address, instruction, immediate,
//          commit enable, halt flag and committed-instruction count out.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  BREAK_FUNCT = 6'h0D
) (
  input logic          CLK,
  input logic          RST,
  instr_fetch_if.slave bus
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        step_q;

  logic [31:0] pc_plus4;
  logic        is_break;
  logic        step_edge;
  logic        exec_en;

  assign pc_plus4  = pc_q + 32'd4;
  assign is_break  = (bus.IMEM_RDATA[31:26] == 6'd0) && (bus.IMEM_RDATA[5:0] == BREAK_FUNCT);
  assign step_edge = bus.STEP & ~step_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    exec_en = 1'b0;
    unique case (state_q)
      StRun: begin
        if (is_break) begin
          // BREAK never commits; PC stays on it for inspection.
          state_d = StHalt;
        end else if (!bus.STEP_MODE || step_edge) begin
          exec_en = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          if (bus.JUMP) begin
            pc_d = {pc_plus4[31:28], bus.IMEM_RDATA[25:0], 2'b00};
          end else if (bus.BRANCH && bus.ZERO) begin
            // Shift by two drops IMM_EXT[31:30]; same result modulo 2^32.
            pc_d = pc_plus4 + (bus.IMM_EXT << 2);
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      step_q  <= bus.STEP;
    end
  end

  assign bus.IMEM_ADDR   = pc_q;
  assign bus.PC          = pc_q;
  assign bus.PC_PLUS4    = pc_plus4;
  assign bus.INSTR       = bus.IMEM_RDATA;
  assign bus.IMM         = bus.IMEM_RDATA[15:0];
  assign bus.EXEC_EN     = exec_en;
  assign bus.HALTED      = (state_q == StHalt);
  assign bus.INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] Nop = 32'h0000_0000;
  localparam logic [31:0] Brk = 32'h0000_000D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (.CLK(clk), .RST(rst), .bus(bus));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.CLK(clk), .RST(rst), .bus(bus2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC / count / halt flag / previous STEP level.
  logic [31:0] m_pc, m_cnt;
  logic        m_halted, m_step_prev, m_valid;
  logic        preload;  // bench has forced the DUT count to all ones this cycle

  initial m_valid = 1'b0;

  function automatic logic m_brk();
    return (bus.IMEM_RDATA[31:26] == 6'd0) && (bus.IMEM_RDATA[5:0] == 6'h0D);
  endfunction

  function automatic logic m_exec();
    return !m_halted && !m_brk() && (!bus.STEP_MODE || (bus.STEP && !m_step_prev));
  endfunction

  function automatic logic [31:0] m_next_pc();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (bus.JUMP) return {p4[31:28], 28'(bus.IMEM_RDATA[25:0]) * 28'd4};
    if (bus.BRANCH && bus.ZERO) return p4 + bus.IMM_EXT * 32'd4;
    return p4;
  endfunction

  always @(posedge clk) begin
    logic        ex;
    logic [31:0] c;
    ex = m_exec();
    c  = preload ? 32'hFFFF_FFFF : m_cnt;
    if (rst) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_halted = 1'b0; m_step_prev = 1'b0; m_valid = 1'b1;
    end else begin
      if (ex) begin
        m_pc  = m_next_pc();
        c     = c + 32'd1;
      end
      m_cnt = c;
      if (!m_halted && m_brk()) m_halted = 1'b1;
      m_step_prev = bus.STEP;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", bus.PC, m_pc);
      chk("imem_addr", bus.IMEM_ADDR, m_pc);
      chk("pc_plus4", bus.PC_PLUS4, m_pc + 32'd4);
      chk("instr", bus.INSTR, bus.IMEM_RDATA);
      chk("imm", {16'h0, bus.IMM}, {16'h0, bus.IMEM_RDATA[15:0]});
      chk("exec_en", {31'h0, bus.EXEC_EN}, {31'h0, m_exec()});
      chk("halted", {31'h0, bus.HALTED}, {31'h0, m_halted});
      chk("instr_count", bus.INSTR_COUNT, preload ? 32'hFFFF_FFFF : m_cnt);
    end
  end

  task automatic set_in(input logic [31:0] rdata, input logic [31:0] ext, input logic br,
                        input logic z, input logic j, input logic sm, input logic st);
    bus.IMEM_RDATA = rdata;
    bus.IMM_EXT    = ext;
    bus.BRANCH     = br;
    bus.ZERO       = z;
    bus.JUMP       = j;
    bus.STEP_MODE  = sm;
    bus.STEP       = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic sm, input logic st);
    set_in(Nop, 32'h0, 1'b0, 1'b0, 1'b0, sm, st);
  endtask

  initial begin
    preload = 1'b0;
    rst = 1'b1;
    nop(1'b0, 1'b0);
    bus2.IMEM_RDATA = Nop; bus2.IMM_EXT = 32'h0; bus2.BRANCH = 1'b0; bus2.ZERO = 1'b0;
    bus2.JUMP = 1'b0; bus2.STEP_MODE = 1'b0; bus2.STEP = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_count", bus.INSTR_COUNT, 32'h0);
    chk("rst_halted", {31'h0, bus.HALTED}, 32'h0);
    chk("wrap_rst_pc", bus2.PC, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", bus2.PC_PLUS4, 32'h0);
    rst = 1'b0;
    #1 chk("first_exec_en", {31'h0, bus.EXEC_EN}, 32'h1);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", bus.PC, 32'(i) * 32'd4);
      tick();
      if (i == 0) chk("wrap_pc", bus2.PC, 32'h0);
    end
    chk("seq_pc_end", bus.PC, 32'h10);
    chk("seq_count", bus.INSTR_COUNT, 32'd4);

    // Backward branch taken
    set_in(32'h1000_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("branch_imm", {16'h0, bus.IMM}, 32'h0000_FFFC);
    tick();
    chk("branch_taken_pc", bus.PC, 32'h04);
    nop(1'b0, 1'b0);
    repeat (3) tick();
    set_in(32'h1000_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("branch_not_taken_pc", bus.PC, 32'h14);

    // Far branch, then jump with branch also asserted
    set_in(32'h1000_0002, 32'h0400_0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("far_branch_pc", bus.PC, 32'h1000_0020);
    set_in(32'h0800_0040, 32'h0000_0040, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("jump_pc", bus.PC, 32'h1000_0100);
    chk("jump_count", bus.INSTR_COUNT, 32'd11);

    // Single-step
    nop(1'b1, 1'b0);
    #1 chk("step_idle_exec_en", {31'h0, bus.EXEC_EN}, 32'h0);
    repeat (5) tick();
    chk("step_idle_pc", bus.PC, 32'h1000_0100);
    nop(1'b1, 1'b1);
    repeat (10) tick();
    chk("step_once_pc", bus.PC, 32'h1000_0104);
    chk("step_once_count", bus.INSTR_COUNT, 32'd12);
    nop(1'b0, 1'b1);
    repeat (2) tick();
    chk("resume_pc", bus.PC, 32'h1000_010C);
    nop(1'b1, 1'b1);
    repeat (3) tick();
    chk("step_held_pc", bus.PC, 32'h1000_010C);
    nop(1'b1, 1'b0);
    tick();
    nop(1'b1, 1'b1);
    tick();
    chk("step_again_pc", bus.PC, 32'h1000_0110);
    chk("step_again_count", bus.INSTR_COUNT, 32'd15);

    // Reset on a committing edge
    nop(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_commit_pc", bus.PC, 32'h0);
    chk("rst_commit_count", bus.INSTR_COUNT, 32'h0);

    // BREAK at 0x20
    repeat (8) tick();
    set_in(Brk, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("break_exec_en", {31'h0, bus.EXEC_EN}, 32'h0);
    tick();
    chk("break_halted", {31'h0, bus.HALTED}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      set_in(i[0] ? Nop : Brk, 32'h4, 1'b1, 1'b1, 1'b1, i[1], i[0]);
      tick();
    end
    chk("halt_pc", bus.PC, 32'h20);
    chk("halt_count", bus.INSTR_COUNT, 32'd8);
    nop(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_rst_pc", bus.PC, 32'h0);
    chk("halt_rst_halted", {31'h0, bus.HALTED}, 32'h0);

    // Counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    preload = 1'b1;
    #1 release dut.cnt_q;
    tick();
    preload = 1'b0;
    chk("count_wrap", bus.INSTR_COUNT, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and instruction-fetch stage of the single-cycle MIPS core: holds the PC, drives the instruction-memory address, and presents the fetched word and its 16-bit immediate field to the sign-extension stage. It consumes the 32-bit sign-extended immediate back to form branch targets and selects the next PC. It also provides run / single-step / halt control for on-board debugging on the Nexys4 DDR.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `BREAK_FUNCT`, 6'h0D, funct code that, with opcode 0, halts fetch.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `IMEM_RDATA`  in  32  instruction word at `IMEM_ADDR`; combinational read, same cycle.
- `IMM_EXT`  in  32  sign-extended `IMM`, returned from the sign-extension stage.
- `BRANCH`  in  1  current instruction is a conditional branch.
- `ZERO`  in  1  ALU zero flag for the current instruction.
- `JUMP`  in  1  current instruction is `j`.
- `STEP_MODE`  in  1  1 = single-step, 0 = free run.
- `STEP`  in  1  debounced step button, level.
- `IMEM_ADDR`  out  32  equals `PC`.
- `PC`  out  32  current program counter.
- `PC_PLUS4`  out  32  `PC + 4`, used for `jal` link data.
- `INSTR`  out  32  `IMEM_RDATA` passed through.
- `IMM`  out  16  `INSTR[15:0]`, sent to the sign-extension stage.
- `EXEC_EN`  out  1  current instruction commits this cycle; gates register-file and data-memory writes.
- `HALTED`  out  1  BREAK reached; fetch is frozen.
- `INSTR_COUNT`  out  32  number of committed instructions.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Step edge: `step_q` registers `STEP`. A step edge is `STEP & ~step_q`.
- `is_break`: `INSTR[31:26]==0` and `INSTR[5:0]==BREAK_FUNCT`.
- `EXEC_EN` is 1 only when all of the following hold:
  - state is RUN;
  - `is_break` is 0;
  - either `STEP_MODE` is 0, or a step edge is present this cycle.
- Next-PC priority, applied only when `EXEC_EN` is 1:
  1. If `JUMP`: `{PC_PLUS4[31:28], INSTR[25:0], 2'b00}`.
  2. Else if `BRANCH & ZERO`: `PC_PLUS4 + {IMM_EXT[29:0], 2'b00}`.
  3. Else: `PC_PLUS4`.
- When `EXEC_EN` is 0, `PC` holds.
- All arithmetic is 32-bit modulo 2^32. Carries out are discarded and PC wraps silently. `PC[1:0]` stays 0 as long as `RESET_PC` is word-aligned.
- In RUN with `is_break` set (regardless of `STEP_MODE`/`STEP`):
  - go to HALT on the next edge;
  - `PC` holds at the BREAK address;
  - the BREAK itself does not commit and is not counted.
- HALT:
  - `HALTED`=1, `EXEC_EN`=0;
  - `PC`, `INSTR_COUNT` and state frozen;
  - exit only via `RST`.
- `INSTR_COUNT` increments by 1 on every edge where `EXEC_EN`=1. It wraps from 32'hFFFF_FFFF to 0.
- `RST` has priority over everything, including mid-step and HALT.

## Timing
- Reset values, visible after the first edge with `RST`=1:
  - `PC` = `RESET_PC`
  - state = RUN, `HALTED` = 0
  - `INSTR_COUNT` = 0
  - `step_q` = 0
- Combinational outputs after reset: `IMEM_ADDR`/`PC_PLUS4`/`INSTR`/`IMM` follow `PC` and `IMEM_RDATA`. `EXEC_EN` follows its equation.
- Latency: `IMEM_ADDR`/`INSTR`/`IMM`/`EXEC_EN` are combinational from `PC`, `IMEM_RDATA`, the control inputs and the step edge. PC, state and counter are registered, giving one instruction per cycle in free run.
- Feedback path `IMM` → sign-extension stage → `IMM_EXT` is combinational and terminates at the PC register. No combinational loop exists.
- Step mode:
  - `STEP` held high produces exactly one commit, on the edge that registers the rise.
  - Holding it longer produces no further commits.
  - `STEP` already high when `STEP_MODE` rises produces no commit until it goes low and high again.
- Switching `STEP_MODE` 1→0 resumes free run on the next cycle.
- `RST` asserted on the same edge as a commit: reset values win, and no count increment occurs.

## Test plan
- **Reset:** `RST` for 2 cycles, `RESET_PC`=0 → `PC`=0, `INSTR_COUNT`=0, `HALTED`=0. First release cycle has `EXEC_EN`=1 with a NOP fetched.
- **Sequential fetch and branch:**
  - 4 NOPs free-run → `PC` steps 0,4,8,C and `INSTR_COUNT`=4.
  - At `PC`=0x10, `BRANCH`=`ZERO`=1 with `IMM`=16'hFFFC (`IMM_EXT`=FFFF_FFFC) → next `PC`=0x04.
  - Same branch with `ZERO`=0 → 0x14.
- **Jump priority:** `PC`=0x1000_0020, `JUMP`=1, `BRANCH`=`ZERO`=1, `INSTR[25:0]`=26'h0000040 → next `PC`=0x1000_0100.
- **Single-step:**
  - `STEP_MODE`=1, `STEP` low 5 cycles → `PC` constant, `EXEC_EN`=0.
  - `STEP` high 10 cycles → exactly one PC advance (+4), `INSTR_COUNT`+1.
- **BREAK:**
  - `IMEM_RDATA`=32'h0000_000D at `PC`=0x20 → `EXEC_EN`=0 that cycle, `HALTED`=1 next cycle.
  - `PC` stays 0x20 and count unchanged for 20 cycles, then `RST` → `PC`=0, `HALTED`=0.
- **Wrap-around:**
  - `RESET_PC`=32'hFFFF_FFFC, one NOP → `PC`=0.
  - Preload of `INSTR_COUNT` to FFFF_FFFF (force), one commit → `INSTR_COUNT`=0.
